// File: rtl/vga_pkg.sv
// vga_pkg: shared widths, default screen bounds and arbiter FSM states
package vga_pkg;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int XMAX_D = 159;
  localparam int YMAX_D = 119;
  typedef enum logic {IDLE, CLEAR} state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin one-hot grant with registered priority pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            accept,
  input  logic [NREQ-1:0] valid,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   idx
);
  // ptr names the requester with top priority, i.e. one past the last grant
  logic [PW-1:0] ptr;
  logic found;
  always_comb begin
    grant = '0;
    idx = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (en && !found && valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx = PW'((int'(ptr) + k) % NREQ);
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (accept) ptr <= PW'((int'(idx) + 1) % NREQ);
endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the VGA pixel-write port among NREQ engines plus a full-screen clear sweep
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int XMAX = XMAX_D,
  parameter int YMAX = YMAX_D
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [X_W*NREQ-1:0] req_x,
  input  logic [Y_W*NREQ-1:0] req_y,
  input  logic [C_W*NREQ-1:0] req_color,
  input  logic                clear_start,
  input  logic [C_W-1:0]      clear_color,
  output logic                busy,
  output logic [7:0]          drop_count,
  output logic [X_W-1:0]      VGA_X,
  output logic [Y_W-1:0]      VGA_Y,
  output logic [C_W-1:0]      VGA_COLOR,
  output logic                plot
);
  localparam int PW = $clog2(NREQ);
  state_t state, state_n;
  logic [PW-1:0] idx;
  logic [X_W-1:0] sx, sel_x;
  logic [Y_W-1:0] sy, sel_y;
  logic [C_W-1:0] sel_c;
  logic accept, in_range, last;
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk(CLOCK_50),
    .rst(reset),
    .en(state == IDLE && !clear_start),
    .accept(accept),
    .valid(req_valid),
    .grant(req_ready),
    .idx(idx)
  );
  assign accept = |req_ready;
  assign sel_x = req_x[int'(idx)*X_W +: X_W];
  assign sel_y = req_y[int'(idx)*Y_W +: Y_W];
  assign sel_c = req_color[int'(idx)*C_W +: C_W];
  assign in_range = int'(sel_x) <= XMAX && int'(sel_y) <= YMAX;
  assign last = int'(sx) == XMAX && int'(sy) == YMAX;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb
    state_n = (state == IDLE) ? (clear_start ? CLEAR : IDLE) : (last ? IDLE : CLEAR);
  // sx/sy track the sweep pixel currently on the outputs; VGA_COLOR holds the latched fill colour
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      VGA_X <= '0;
      VGA_Y <= '0;
      VGA_COLOR <= '0;
      plot <= 1'b0;
      busy <= 1'b0;
      drop_count <= '0;
      sx <= '0;
      sy <= '0;
    end else if (state == IDLE) begin
      if (clear_start) begin
        sx <= '0;
        sy <= '0;
        VGA_X <= '0;
        VGA_Y <= '0;
        VGA_COLOR <= clear_color;
        plot <= 1'b1;
        busy <= 1'b1;
      end else if (accept && in_range) begin
        VGA_X <= sel_x;
        VGA_Y <= sel_y;
        VGA_COLOR <= sel_c;
        plot <= 1'b1;
      end else begin
        plot <= 1'b0;
        if (accept && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end else if (last) begin
      plot <= 1'b0;
      busy <= 1'b0;
    end else begin
      sx <= (int'(sx) == XMAX) ? '0 : sx + X_W'(1);
      sy <= (int'(sx) == XMAX) ? sy + Y_W'(1) : sy;
      VGA_X <= (int'(sx) == XMAX) ? '0 : sx + X_W'(1);
      VGA_Y <= (int'(sx) == XMAX) ? sy + Y_W'(1) : sy;
      plot <= 1'b1;
    end
endmodule

// File: tb/tb_vga_plot_arbiter.sv
// tb_vga_plot_arbiter: directed self-checking bench for the VGA plot arbiter
module tb_vga_plot_arbiter;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [1:0] req_valid = '0;
  logic [1:0] req_ready;
  logic [15:0] req_x = '0;
  logic [13:0] req_y = '0;
  logic [5:0] req_color = '0;
  logic clear_start = 1'b0;
  logic [2:0] clear_color = '0;
  logic busy, plot;
  logic [7:0] drop_count, VGA_X;
  logic [6:0] VGA_Y;
  logic [2:0] VGA_COLOR;
  int checks = 0;
  int errors = 0;

  vga_plot_arbiter #(.NREQ(2), .XMAX(159), .YMAX(119)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_color(req_color), .clear_start(clear_start),
    .clear_color(clear_color), .busy(busy), .drop_count(drop_count), .VGA_X(VGA_X),
    .VGA_Y(VGA_Y), .VGA_COLOR(VGA_COLOR), .plot(plot)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic set_req(input int i, input logic v, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_valid[i] = v;
    req_x[i*8 +: 8] = x;
    req_y[i*7 +: 7] = y;
    req_color[i*3 +: 3] = c;
  endtask

  task automatic test_reset;
    logic [28:0] exp0 = '0;
    repeat (2) @(negedge CLOCK_50);
    checks++;
    if ({VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count} !== exp0) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", {VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count}, exp0);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL idle_ready: got %b expected 00", req_ready);
    end
    set_req(0, 1'b1, 8'd33, 7'd44, 3'd6);
    @(posedge CLOCK_50);
    #2;
    checks++;
    if (plot !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_plot: got %b expected 1", plot);
    end
    set_req(0, 1'b0, 8'd0, 7'd0, 3'd0);
    reset = 1'b1;
    #1;
    checks++;
    if ({VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count} !== exp0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", {VGA_X, VGA_Y, VGA_COLOR, plot, busy, drop_count}, exp0);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL post_reset_ready: got %b expected 00", req_ready);
    end
  endtask

  task automatic test_single;
    @(negedge CLOCK_50);
    set_req(0, 1'b1, 8'd10, 7'd20, 3'd5);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", req_ready);
    end
    @(negedge CLOCK_50);
    set_req(0, 1'b0, 8'd0, 7'd0, 3'd0);
    checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 8'd10, 7'd20, 3'd5}) begin
      errors++;
      $display("FAIL single_pixel: got %h expected %h", {plot, VGA_X, VGA_Y, VGA_COLOR}, {1'b1, 8'd10, 7'd20, 3'd5});
    end
    @(negedge CLOCK_50);
    checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b0, 8'd10, 7'd20, 3'd5}) begin
      errors++;
      $display("FAIL single_hold: got %h expected %h", {plot, VGA_X, VGA_Y, VGA_COLOR}, {1'b0, 8'd10, 7'd20, 3'd5});
    end
  endtask

  task automatic test_fairness;
    logic [15:0] exp_px = '0;
    logic [1:0] exp_g;
    @(negedge CLOCK_50);
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLOCK_50);
      if (c > 0) begin
        checks++;
        if ({plot, VGA_X, VGA_Y} !== exp_px) begin
          errors++;
          $display("FAIL fair_plot c=%0d: got %h expected %h", c, {plot, VGA_X, VGA_Y}, exp_px);
        end
      end
      set_req(0, 1'b1, 8'(c), 7'd1, 3'd1);
      set_req(1, 1'b1, 8'(100 + c), 7'd2, 3'd2);
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      checks++;
      if (req_ready !== exp_g) begin
        errors++;
        $display("FAIL fair_grant c=%0d: got %b expected %b", c, req_ready, exp_g);
      end
      exp_px = (c % 2 == 0) ? {1'b1, 8'(c), 7'd1} : {1'b1, 8'(100 + c), 7'd2};
    end
    @(negedge CLOCK_50);
    set_req(0, 1'b0, 8'd0, 7'd0, 3'd0);
    set_req(1, 1'b0, 8'd0, 7'd0, 3'd0);
    checks++;
    if ({plot, VGA_X, VGA_Y} !== {1'b1, 8'd105, 7'd2}) begin
      errors++;
      $display("FAIL fair_last: got %h expected %h", {plot, VGA_X, VGA_Y}, {1'b1, 8'd105, 7'd2});
    end
    @(negedge CLOCK_50);
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL fair_end: got %b expected 0", plot);
    end
  endtask

  task automatic test_drop;
    @(negedge CLOCK_50);
    set_req(1, 1'b1, 8'd160, 7'd5, 3'd3);
    #1;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL drop_ready: got %b expected 10", req_ready);
    end
    @(negedge CLOCK_50);
    set_req(1, 1'b1, 8'd0, 7'd120, 3'd3);
    checks++;
    if ({plot, drop_count, VGA_X} !== {1'b0, 8'd1, 8'd105}) begin
      errors++;
      $display("FAIL drop_x: got %h expected %h", {plot, drop_count, VGA_X}, {1'b0, 8'd1, 8'd105});
    end
    @(negedge CLOCK_50);
    set_req(1, 1'b1, 8'd159, 7'd119, 3'd4);
    checks++;
    if ({plot, drop_count} !== {1'b0, 8'd2}) begin
      errors++;
      $display("FAIL drop_y: got %h expected %h", {plot, drop_count}, {1'b0, 8'd2});
    end
    @(negedge CLOCK_50);
    set_req(1, 1'b1, 8'd200, 7'd100, 3'd0);
    checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR, drop_count} !== {1'b1, 8'd159, 7'd119, 3'd4, 8'd2}) begin
      errors++;
      $display("FAIL edge_pixel: got %h expected %h", {plot, VGA_X, VGA_Y, VGA_COLOR, drop_count}, {1'b1, 8'd159, 7'd119, 3'd4, 8'd2});
    end
    repeat (300) @(negedge CLOCK_50);
    set_req(1, 1'b0, 8'd0, 7'd0, 3'd0);
    checks++;
    if ({plot, drop_count} !== {1'b0, 8'd255}) begin
      errors++;
      $display("FAIL drop_sat: got %h expected %h", {plot, drop_count}, {1'b0, 8'd255});
    end
  endtask

  task automatic test_clear;
    logic [20:0] exp_s;
    @(negedge CLOCK_50);
    set_req(0, 1'b1, 8'd7, 7'd8, 3'd1);
    clear_start = 1'b1;
    clear_color = 3'd2;
    #1;
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL clear_wins: got %b expected 00", req_ready);
    end
    for (int k = 0; k < 19200; k++) begin
      @(negedge CLOCK_50);
      clear_start = (k == 100);
      clear_color = (k == 100) ? 3'd5 : 3'd2;
      exp_s = {2'b00, 1'b1, 1'b1, 8'(k % 160), 7'(k / 160), 3'd2};
      checks++;
      if ({req_ready, busy, plot, VGA_X, VGA_Y, VGA_COLOR} !== exp_s) begin
        errors++;
        $display("FAIL sweep k=%0d: got %h expected %h", k, {req_ready, busy, plot, VGA_X, VGA_Y, VGA_COLOR}, exp_s);
      end
    end
    @(negedge CLOCK_50);
    checks++;
    if ({req_ready, busy, plot} !== 4'b0100) begin
      errors++;
      $display("FAIL clear_end: got %b expected 0100", {req_ready, busy, plot});
    end
    @(negedge CLOCK_50);
    set_req(0, 1'b0, 8'd0, 7'd0, 3'd0);
    checks++;
    if ({plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 8'd7, 7'd8, 3'd1}) begin
      errors++;
      $display("FAIL after_clear: got %h expected %h", {plot, VGA_X, VGA_Y, VGA_COLOR}, {1'b1, 8'd7, 7'd8, 3'd1});
    end
  endtask

  task automatic test_abort;
    @(negedge CLOCK_50);
    clear_start = 1'b1;
    clear_color = 3'd3;
    for (int k = 0; k <= 500; k++) begin
      @(negedge CLOCK_50);
      clear_start = 1'b0;
    end
    checks++;
    if ({busy, VGA_X, VGA_Y} !== {1'b1, 8'd20, 7'd3}) begin
      errors++;
      $display("FAIL abort_pos: got %h expected %h", {busy, VGA_X, VGA_Y}, {1'b1, 8'd20, 7'd3});
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({busy, plot, VGA_X, VGA_Y, VGA_COLOR, drop_count} !== 28'd0) begin
      errors++;
      $display("FAIL abort_reset: got %h expected 0", {busy, plot, VGA_X, VGA_Y, VGA_COLOR, drop_count});
    end
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if ({busy, plot} !== 2'b00) begin
      errors++;
      $display("FAIL abort_no_resume: got %b expected 00", {busy, plot});
    end
    clear_start = 1'b1;
    @(negedge CLOCK_50);
    clear_start = 1'b0;
    checks++;
    if ({busy, plot, VGA_X, VGA_Y, VGA_COLOR} !== {1'b1, 1'b1, 8'd0, 7'd0, 3'd3}) begin
      errors++;
      $display("FAIL restart_origin: got %h expected %h", {busy, plot, VGA_X, VGA_Y, VGA_COLOR}, {1'b1, 1'b1, 8'd0, 7'd0, 3'd3});
    end
    @(negedge CLOCK_50);
    checks++;
    if ({VGA_X, VGA_Y} !== {8'd1, 7'd0}) begin
      errors++;
      $display("FAIL restart_next: got %h expected %h", {VGA_X, VGA_Y}, {8'd1, 7'd0});
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_drop();
    test_clear();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
